// File: rtl/serial_bus_arbiter.sv
// Round-robin arbiter for the shared internal serial bus: one-hot grant,
// hold limit with timeout pulse, and a fixed idle gap between tenures.
module serial_bus_arbiter #(
  parameter int MASTER_COUNT = 2,
  parameter int FIRST_MASTER = 0,
  parameter int MAX_HOLD     = 4096,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [MASTER_COUNT-1:0]         req,
  input  logic [MASTER_COUNT-1:0]         done,
  output logic [MASTER_COUNT-1:0]         grant,
  output logic [$clog2(MASTER_COUNT)-1:0] owner,
  output logic                            bus_busy,
  output logic                            timeout
);

  localparam int OW = $clog2(MASTER_COUNT);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  localparam logic [OW-1:0]           OWNER_RST  = OW'(FIRST_MASTER);
  localparam logic [OW-1:0]           LAST_RST   = OW'((FIRST_MASTER + MASTER_COUNT - 1) % MASTER_COUNT);
  localparam logic [HW-1:0]           HOLD_LIMIT = HW'(MAX_HOLD - 1);
  localparam logic [3:0]              GAP_LOAD   = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [MASTER_COUNT-1:0] ONE_HOT0   = MASTER_COUNT'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                  state_r;
  logic [MASTER_COUNT-1:0] grant_r;
  logic [OW-1:0]           owner_r;
  logic [OW-1:0]           last_r;
  logic [HW-1:0]           hold_r;
  logic [3:0]              gap_r;
  logic                    busy_r;
  logic                    timeout_r;

  logic [OW-1:0]           pick_s;
  logic                    found_s;
  logic                    rel_done_s;
  logic                    rel_drop_s;
  logic                    rel_hold_s;
  logic                    release_s;
  logic                    sole_hold_s;

  // Cyclic search from last_r+1; iterating downwards lets the nearest requester win.
  always_comb begin
    logic [OW-1:0] idx;
    pick_s  = last_r;
    found_s = 1'b0;
    for (int k = MASTER_COUNT; k >= 1; k--) begin
      idx     = OW'((int'(last_r) + k) % MASTER_COUNT);
      pick_s  = req[idx] ? idx : pick_s;
      found_s = found_s | req[idx];
    end
  end

  // Release causes of the current tenure; timeout only when the hold limit acts alone.
  always_comb begin
    rel_done_s  = done[owner_r];
    rel_drop_s  = ~req[owner_r];
    rel_hold_s  = (hold_r == HOLD_LIMIT);
    release_s   = rel_done_s | rel_drop_s | rel_hold_s;
    sole_hold_s = rel_hold_s & ~rel_done_s & ~rel_drop_s;
  end

  // Arbitration state machine with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      grant_r   <= '0;
      busy_r    <= 1'b0;
      timeout_r <= 1'b0;
      owner_r   <= OWNER_RST;
      last_r    <= LAST_RST;
      hold_r    <= '0;
      gap_r     <= 4'd0;
    end else begin
      timeout_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (found_s) begin
            grant_r <= ONE_HOT0 << pick_s;
            busy_r  <= 1'b1;
            owner_r <= pick_s;
            last_r  <= pick_s;
            hold_r  <= '0;
            state_r <= BUSY;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (release_s) begin
            grant_r   <= '0;
            busy_r    <= 1'b0;
            timeout_r <= sole_hold_s;
            gap_r     <= GAP_LOAD;
            state_r   <= (GAP_CYCLES == 0) ? IDLE : GAP;
          end else begin
            hold_r <= hold_r + HW'(1);
          end
        end
        GAP: begin
          if (gap_r == 4'd0) begin
            state_r <= IDLE;
          end else begin
            gap_r <= gap_r - 4'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          grant_r <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign grant    = grant_r;
  assign owner    = owner_r;
  assign bus_busy = busy_r;
  assign timeout  = timeout_r;

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Directed bench: instance A (FIRST_MASTER=0, MAX_HOLD=16, GAP=2) and
// instance B (FIRST_MASTER=1, MAX_HOLD=8, GAP=0).
module tb_serial_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [1:0] req_a, done_a, grant_a;
  logic [1:0] req_b, done_b, grant_b;
  logic       owner_a, busy_a, to_a;
  logic       owner_b, busy_b, to_b;

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0] exp_seq [3] = '{2'b10, 2'b01, 2'b10};

  always #5 clk = ~clk;

  serial_bus_arbiter #(.MASTER_COUNT(2), .FIRST_MASTER(0), .MAX_HOLD(16), .GAP_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst_a), .req(req_a), .done(done_a),
    .grant(grant_a), .owner(owner_a), .bus_busy(busy_a), .timeout(to_a)
  );

  serial_bus_arbiter #(.MASTER_COUNT(2), .FIRST_MASTER(1), .MAX_HOLD(8), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst_b), .req(req_b), .done(done_b),
    .grant(grant_b), .owner(owner_b), .bus_busy(busy_b), .timeout(to_b)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    req_a = 2'b00; done_a = 2'b00;
    req_b = 2'b00; done_b = 2'b00;
    tick; tick;

    check_val("rst_a_grant", 32'(grant_a), 32'h0);
    check_val("rst_a_owner", 32'(owner_a), 32'h0);
    check_val("rst_a_busy",  32'(busy_a),  32'h0);
    check_val("rst_a_to",    32'(to_a),    32'h0);
    check_val("rst_b_grant", 32'(grant_b), 32'h0);
    check_val("rst_b_owner", 32'(owner_b), 32'h1);

    // Single requester, done after 10 cycles of grant
    rst_a = 1'b0; rst_b = 1'b0;
    req_a = 2'b01;
    tick;
    check_val("t1_grant", 32'(grant_a), 32'h1);
    check_val("t1_owner", 32'(owner_a), 32'h0);
    check_val("t1_busy",  32'(busy_a),  32'h1);
    for (int i = 0; i < 9; i++) begin
      tick;
      check_val("t1_hold",      32'(grant_a), 32'h1);
      check_val("t1_hold_busy", 32'(busy_a),  32'h1);
    end
    done_a = 2'b01;
    tick;
    done_a = 2'b00; req_a = 2'b00;
    check_val("t1_rel_grant", 32'(grant_a), 32'h0);
    check_val("t1_rel_busy",  32'(busy_a),  32'h0);
    check_val("t1_rel_to",    32'(to_a),    32'h0);
    check_val("t1_rel_owner", 32'(owner_a), 32'h0);
    tick; tick; tick;
    check_val("t1_idle_grant", 32'(grant_a), 32'h0);

    // Contention, 5-cycle tenures, 3 low cycles between them
    req_a = 2'b11;
    for (int t = 0; t < 3; t++) begin
      tick;
      check_val("ct_grant", 32'(grant_a), 32'(exp_seq[t]));
      check_val("ct_owner", 32'(owner_a), (exp_seq[t] == 2'b10) ? 32'h1 : 32'h0);
      for (int i = 0; i < 4; i++) begin
        tick;
        check_val("ct_hold", 32'(grant_a), 32'(exp_seq[t]));
      end
      done_a = exp_seq[t];
      tick;
      done_a = 2'b00;
      check_val("ct_rel",    32'(grant_a), 32'h0);
      check_val("ct_rel_to", 32'(to_a),    32'h0);
      tick;
      check_val("ct_gap1", 32'(grant_a), 32'h0);
      tick;
      check_val("ct_gap2", 32'(grant_a), 32'h0);
    end
    req_a = 2'b00;
    tick;
    check_val("ct_end", 32'(grant_a), 32'h0);

    // Non-owner noise then owner drops its request
    req_a = 2'b01;
    tick;
    check_val("nz_grant", 32'(grant_a), 32'h1);
    done_a = 2'b10; req_a = 2'b11;
    tick;
    check_val("nz_hold",  32'(grant_a), 32'h1);
    check_val("nz_owner", 32'(owner_a), 32'h0);
    done_a = 2'b00; req_a = 2'b01;
    tick;
    check_val("nz_hold2", 32'(grant_a), 32'h1);
    req_a = 2'b00;
    tick;
    check_val("nz_drop",    32'(grant_a), 32'h0);
    check_val("nz_drop_to", 32'(to_a),    32'h0);
    check_val("nz_busy",    32'(busy_a),  32'h0);

    // Instance B: reset mid-tenure with FIRST_MASTER=1
    req_b = 2'b01;
    tick;
    check_val("rb_grant", 32'(grant_b), 32'h1);
    check_val("rb_owner", 32'(owner_b), 32'h0);
    tick;
    rst_b = 1'b1;
    tick;
    check_val("rb_rst_grant", 32'(grant_b), 32'h0);
    check_val("rb_rst_busy",  32'(busy_b),  32'h0);
    check_val("rb_rst_to",    32'(to_b),    32'h0);
    check_val("rb_rst_owner", 32'(owner_b), 32'h1);
    rst_b = 1'b0; req_b = 2'b11;
    tick;
    check_val("rb_first", 32'(grant_b), 32'h2);
    check_val("rb_first_owner", 32'(owner_b), 32'h1);

    // Timeout after exactly 8 cycles, then re-grant after one low cycle
    req_b = 2'b10;
    for (int i = 0; i < 7; i++) begin
      tick;
      check_val("to_hold",    32'(grant_b), 32'h2);
      check_val("to_hold_to", 32'(to_b),    32'h0);
    end
    tick;
    check_val("to_rel",   32'(grant_b), 32'h0);
    check_val("to_pulse", 32'(to_b),    32'h1);
    check_val("to_busy",  32'(busy_b),  32'h0);
    tick;
    check_val("to_regrant", 32'(grant_b), 32'h2);
    check_val("to_clear",   32'(to_b),    32'h0);

    // Coincident done and hold limit: release without timeout
    for (int i = 0; i < 7; i++) begin
      tick;
      check_val("co_hold", 32'(grant_b), 32'h2);
    end
    done_b = 2'b10;
    tick;
    done_b = 2'b00;
    check_val("co_rel", 32'(grant_b), 32'h0);
    check_val("co_to",  32'(to_b),    32'h0);
    req_b = 2'b00;
    tick;
    check_val("co_idle", 32'(grant_b), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
